// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: state encoding, default depth, lane count.
package dmem_pkg;

    localparam int DEPTH_WORDS_DEF = 1024;
    localparam int LANES           = 4;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RESP = 1'b1;

endpackage

// File: rtl/dmem_ram.sv
// Single-port byte-lane-writable word memory; the read data of a write access is the merged new word.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic [LANES-1:0]     wbe,
    input  logic [IDX_W-1:0]     idx,
    input  logic [8*LANES-1:0]   wdata,
    output logic [8*LANES-1:0]   rdata
);

    logic [LANES-1:0][7:0] mem [DEPTH_WORDS];

    // Contents are deliberately not reset; rdata is only meaningful after an access.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wbe[i]) begin
                    mem[idx][i] <= wdata[8*i +: 8];
                end
                rdata[8*i +: 8] <= wbe[i] ? wdata[8*i +: 8] : mem[idx][i];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// One-outstanding-request data-memory responder with range checking.
// Optional DMEM_MISALIGN_ERR_EN: a request with no byte lanes enabled is rejected.
//
// state   | meaning
// IDLE    | ready for a request; req_ready high outside reset
// RESP    | response held on rsp_* until rsp_ready
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_be,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int WIDX_W = ADDR_W - 2;
    localparam logic [WIDX_W-1:0] DEPTH_LIMIT = WIDX_W'(DEPTH_WORDS);

    state_t            state;
    logic              err_q;
    logic [WIDX_W-1:0] word_idx;
    logic              in_range;
    logic              be_err;
    logic              req_err;
    logic              accept;
    logic              ram_en;
    logic [LANES-1:0]  ram_wbe;
    logic [31:0]       ram_rdata;
    logic              unused_addr_lsb;

    assign word_idx        = req_addr[ADDR_W-1:2];
    assign unused_addr_lsb = ^req_addr[1:0];
    assign in_range        = (word_idx < DEPTH_LIMIT);

`ifdef DMEM_MISALIGN_ERR_EN
    assign be_err = (req_be == 4'b0000);
`else
    assign be_err = 1'b0;
`endif

    assign req_err = ~in_range | be_err;
    assign accept  = req_valid & req_ready;

    // Rejected requests never touch the array, so an out-of-range index cannot alias a real word.
    assign ram_en  = accept & ~req_err;
    assign ram_wbe = req_we ? req_be : '0;

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .wbe   (ram_wbe),
        .idx   (word_idx[IDX_W-1:0]),
        .wdata (req_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            err_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_RESP;
                        err_q <= req_err;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ram_rdata only changes on an accept, which cannot happen in RESP, so the response stays stable.
    assign req_ready = (state == ST_IDLE) & ~reset;
    assign rsp_valid = (state == ST_RESP);
    assign rsp_err   = rsp_valid & err_q;
    assign rsp_rdata = (rsp_valid & ~err_q) ? ram_rdata : 32'h0;

endmodule
